// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states, per-stage control bundle and register constants.
package pipeline_hazard_ctrl_pkg;

    localparam logic [4:0] REG_G0     = 5'd0;
    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic idex_bubble;
        logic ifid_flush;
        logic pc_redirect;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD = '0;
    localparam ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_REDIR = '{1'b1, 1'b1, 1'b1, 1'b1,
                                     1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1,
                                      1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the sources of ID.
// g0 is hardwired to zero, so it never creates a dependency.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic       uses_rs2_id_i,
    input  logic [4:0] rd_ex_i,
    input  logic       mem_read_ex_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (rd_ex_i == rs1_id_i);
    assign rs2_hit = uses_rs2_id_i & (rd_ex_i == rs2_id_i);

    assign load_use_o = mem_read_ex_i & (rd_ex_i != REG_G0)
                      & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use interlock, control-transfer redirect
// and data-memory wait handling with a sticky timeout error.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             rs1_ID,
    input  logic [4:0]             rs2_ID,
    input  logic                   uses_rs2_ID,
    input  logic [4:0]             rd_EX,
    input  logic                   mem_read_EX,
    input  logic                   branch_taken_EX,
    input  logic                   call_EX,
    input  logic                   jmpl_EX,
    input  logic                   mem_req_MEM,
    input  logic                   mem_ack,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   idex_we,
    output logic                   exmem_we,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic                   pc_redirect,
    output logic                   mem_timeout_err,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE  = WAIT_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    logic load_use;
    logic freeze;
    logic redirect;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                    err_q, err_d;
    ctrl_t                   ctrl;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .rs1_id_i      (rs1_ID),
        .rs2_id_i      (rs2_ID),
        .uses_rs2_id_i (uses_rs2_ID),
        .rd_ex_i       (rd_EX),
        .mem_read_ex_i (mem_read_EX),
        .load_use_o    (load_use)
    );

    assign freeze   = mem_req_MEM & ~mem_ack;
    assign redirect = branch_taken_EX | call_EX | jmpl_EX;

    always_comb begin
        ctrl = CTRL_HOLD;
        if (!rst_n || state_q == ST_ERR || freeze) begin
            ctrl = CTRL_HOLD;
        end else if (redirect) begin
            ctrl = CTRL_REDIR;
        end else if (load_use && state_q == ST_RUN) begin
            ctrl = CTRL_BUBBLE;
        end else begin
            ctrl = CTRL_RUN;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else if (load_use && !redirect) begin
                    state_d = ST_LD_STALL;
                end
            end
            ST_LD_STALL: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!freeze) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating: a long stall run must never wrap back to a small value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((freeze || ctrl.idex_bubble) && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign pc_we           = ctrl.pc_we;
    assign ifid_we         = ctrl.ifid_we;
    assign idex_we         = ctrl.idex_we;
    assign exmem_we        = ctrl.exmem_we;
    assign idex_bubble     = ctrl.idex_bubble;
    assign ifid_flush      = ctrl.ifid_flush;
    assign pc_redirect     = ctrl.pc_redirect;
    assign mem_timeout_err = err_q;
    assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: interlock, redirect,
// memory wait, timeout error and stall counter saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       uses_rs2_ID, mem_read_EX;
    logic       branch_taken_EX, call_EX, jmpl_EX;
    logic       mem_req_MEM, mem_ack;

    logic        pc_we, ifid_we, idex_we, exmem_we;
    logic        idex_bubble, ifid_flush, pc_redirect;
    logic        mem_timeout_err;
    logic [15:0] stall_count;

    logic        pc_we4, ifid_we4, idex_we4, exmem_we4;
    logic        idex_bubble4, ifid_flush4, pc_redirect4;
    logic        mem_timeout_err4;
    logic [3:0]  stall_count4;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] EN_HOLD   = 7'b0000000;
    localparam logic [6:0] EN_RUN    = 7'b1111000;
    localparam logic [6:0] EN_BUBBLE = 7'b0011100;
    localparam logic [6:0] EN_REDIR  = 7'b1111011;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.STALL_CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .uses_rs2_ID     (uses_rs2_ID),
        .rd_EX           (rd_EX),
        .mem_read_EX     (mem_read_EX),
        .branch_taken_EX (branch_taken_EX),
        .call_EX         (call_EX),
        .jmpl_EX         (jmpl_EX),
        .mem_req_MEM     (mem_req_MEM),
        .mem_ack         (mem_ack),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .pc_redirect     (pc_redirect),
        .mem_timeout_err (mem_timeout_err),
        .stall_count     (stall_count)
    );

    pipeline_hazard_ctrl #(.STALL_CNT_W(4), .MEM_TIMEOUT(15)) dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .uses_rs2_ID     (uses_rs2_ID),
        .rd_EX           (rd_EX),
        .mem_read_EX     (mem_read_EX),
        .branch_taken_EX (branch_taken_EX),
        .call_EX         (call_EX),
        .jmpl_EX         (jmpl_EX),
        .mem_req_MEM     (mem_req_MEM),
        .mem_ack         (mem_ack),
        .pc_we           (pc_we4),
        .ifid_we         (ifid_we4),
        .idex_we         (idex_we4),
        .exmem_we        (exmem_we4),
        .idex_bubble     (idex_bubble4),
        .ifid_flush      (ifid_flush4),
        .pc_redirect     (pc_redirect4),
        .mem_timeout_err (mem_timeout_err4),
        .stall_count     (stall_count4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] en_vec();
        return {pc_we, ifid_we, idex_we, exmem_we,
                idex_bubble, ifid_flush, pc_redirect};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_ID = 5'd1; rs2_ID = 5'd2; uses_rs2_ID = 1'b0;
        rd_EX = 5'd0; mem_read_EX = 1'b0;
        branch_taken_EX = 1'b0; call_EX = 1'b0; jmpl_EX = 1'b0;
        mem_req_MEM = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_en", 32'(en_vec()), 32'(EN_HOLD));
        check("rst_err", 32'(mem_timeout_err), 32'd0);
        check("rst_cnt", 32'(stall_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #2;
        do_reset();
        check("idle_en", 32'(en_vec()), 32'(EN_RUN));

        // Load-use on rs1: one bubble cycle, then normal.
        mem_read_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5;
        #1;
        check("lu_en", 32'(en_vec()), 32'(EN_BUBBLE));
        tick();
        check("lu_cnt", 32'(stall_count), 32'd1);
        check("lu_once", 32'(en_vec()), 32'(EN_RUN));
        idle();
        tick();
        check("lu_after", 32'(en_vec()), 32'(EN_RUN));

        // g0 and unused rs2 never interlock.
        mem_read_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0;
        #1;
        check("g0_en", 32'(en_vec()), 32'(EN_RUN));
        rd_EX = 5'd5; rs1_ID = 5'd3; rs2_ID = 5'd5; uses_rs2_ID = 1'b0;
        #1;
        check("rs2_unused", 32'(en_vec()), 32'(EN_RUN));
        uses_rs2_ID = 1'b1;
        #1;
        check("rs2_used", 32'(en_vec()), 32'(EN_BUBBLE));
        tick();
        check("rs2_cnt", 32'(stall_count), 32'd2);
        idle();
        tick();

        // Taken branch: one redirect cycle.
        branch_taken_EX = 1'b1;
        #1;
        check("br_en", 32'(en_vec()), 32'(EN_REDIR));
        tick();
        idle();
        #1;
        check("br_once", 32'(en_vec()), 32'(EN_RUN));
        jmpl_EX = 1'b1;
        #1;
        check("jmpl_en", 32'(en_vec()), 32'(EN_REDIR));
        idle();
        tick();

        // Memory wait 3 cycles with a pending redirect held behind it.
        mem_req_MEM = 1'b1; branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_hold", 32'(en_vec()), 32'(EN_HOLD));
            tick();
        end
        check("mw_cnt", 32'(stall_count), 32'd5);
        mem_ack = 1'b1;
        #1;
        check("mw_release", 32'(en_vec()), 32'(EN_REDIR));
        tick();
        idle();
        #1;
        check("mw_after", 32'(en_vec()), 32'(EN_RUN));
        check("mw_cnt2", 32'(stall_count), 32'd5);

        // Timeout: entry cycle plus 15 wait cycles, then ERR.
        mem_req_MEM = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_hold", 32'(en_vec()), 32'(EN_HOLD));
        end
        check("to_early", 32'(mem_timeout_err), 32'd0);
        tick();
        check("to_err", 32'(mem_timeout_err), 32'd1);
        mem_req_MEM = 1'b0;
        #1;
        check("err_en", 32'(en_vec()), 32'(EN_HOLD));
        tick();
        check("err_sticky", 32'(mem_timeout_err), 32'd1);
        check("err_cnt", 32'(stall_count), 32'd21);
        do_reset();
        check("post_rst_err", 32'(mem_timeout_err), 32'd0);
        check("post_rst_en", 32'(en_vec()), 32'(EN_RUN));

        // 20 stall cycles in bursts of 4 separated by ack cycles.
        for (int b = 0; b < 5; b++) begin
            mem_req_MEM = 1'b1; mem_ack = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            mem_ack = 1'b1;
            tick();
            if (b == 2) check("sat_mid", 32'(stall_count4), 32'hC);
        end
        idle();
        tick();
        check("sat4", 32'(stall_count4), 32'hF);
        check("sat16", 32'(stall_count), 32'd20);
        check("sat_err", 32'(mem_timeout_err4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
